usb_tx_sched: RTL and testbench
===============================

USB_TX_SCHED -- requirements
Module: usb_tx_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd1200, meaning the clk cycles allowed after end of DATA transmission for the receiver to report a handshake.
REQ-002 SHALL have parameter MAX_RETRY, default 2'd3, meaning the number of retransmissions allowed after the first attempt.
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-004 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port hs_req, input, 1, receive side requests a handshake packet; level, held until hs_grant.
REQ-006 SHALL have port hs_nak, input, 1, handshake type qualifier: 0=ACK, 1=NAK; sampled when hs_grant is issued.
REQ-007 SHALL have port data_req, input, 1, host requests a DATA1 packet; level, held until data_grant.
REQ-008 SHALL have port data_len, input, 7, payload byte count 1..64; sampled when data_grant is issued.
REQ-009 SHALL have port fifo_rd, input, 1, encoder FIFO read strobe (encoder r_enable_e); one pulse per payload byte.
REQ-010 SHALL have port encode_status, input, 3, encoder status; 3'b010 means packet complete.
REQ-011 SHALL have port rx_ack / rx_nak, input, 1 each, single-cycle receiver handshake indications.
REQ-012 SHALL have port encode_instruction, output, 4, registered command to encoder.
REQ-013 SHALL have port hs_grant / data_grant, output, 1 each, single-cycle acceptance pulses.
REQ-014 SHALL have port fifo_rewind, output, 1, single-cycle pulse restoring the TX FIFO read pointer before a retry.
REQ-015 SHALL have port data_done / data_fail, output, 1 each, single-cycle outcome pulses for a DATA transaction.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL encode instructions: IDLE 4'b0000, ACK 4'b0110, NAK 4'b0011, SYNC+DATA1 PID 4'b0100, payload stream 4'b0101, CRC/end 4'b0111.
REQ-018 SHALL detect done as a rising edge of (encode_status==3'b010); a held status SHALL count once.
REQ-019 SHALL use the states IDLE, HS_ISSUE, HS_WAIT, D_SYNC, D_PAYLOAD, D_CRC, D_TXWAIT, D_RSPWAIT.
REQ-020 SHALL, in IDLE with both requests high, grant hs_req first (fixed priority); the grant pulse is concurrent with leaving IDLE.
REQ-021 SHALL, in HS_ISSUE, drive ACK or NAK code for 1 cycle, then go to HS_WAIT holding the code until done, then return to IDLE with code 0000.
REQ-022 SHALL, in D_SYNC, drive 4'b0100 for 1 cycle, then D_PAYLOAD driving 4'b0101.
REQ-023 SHALL count fifo_rd pulses in D_PAYLOAD with a 7-bit counter; when count equals latched length, go to D_CRC, driving 4'b0111 until done, then D_TXWAIT.
REQ-024 SHALL, in D_TXWAIT, drive 0000 for 1 cycle, load the timeout counter, and enter D_RSPWAIT.
REQ-025 SHALL, in D_RSPWAIT, on rx_ack pulse data_done and go IDLE; on rx_nak or counter reaching 0, retry if retry count < MAX_RETRY, else pulse data_fail and go IDLE.
REQ-026 SHALL, on retry, pulse fifo_rewind, increment the 2-bit retry count, clear the byte counter, and re-enter D_SYNC next cycle.
REQ-027 SHALL give rx_ack precedence when rx_ack and rx_nak or timeout coincide.
REQ-028 SHALL ignore hs_req during a DATA transaction, which is non-preemptible; hs_req SHALL be served in the IDLE cycle after completion.
REQ-029 SHALL ignore rx_ack / rx_nak outside D_RSPWAIT.

Reset
REQ-030 SHALL, on n_rst low, immediately force state IDLE, encode_instruction 0000, all counters 0, and all pulse outputs and busy to 0, including mid-packet.
REQ-031 SHALL leave IDLE no earlier than the first clk edge after n_rst deasserts.

Structure
REQ-032 SHALL place the instruction codes, the status code 3'b010, and the state enum in shared package usb_tx_pkg.
REQ-033 SHALL implement the timeout as sub-module usb_timeout_cnt (load, enable, expire).

Verification
REQ-034 SHALL cover: hs_req=1, hs_nak=0 -> hs_grant 1 cycle; 4'b0110 until status 010; then 0000.
REQ-035 SHALL cover: data_req with data_len=3, 3 fifo_rd, done, rx_ack -> sequence 0100, 0101, 0111, then data_done; no rewind.
REQ-036 SHALL cover: hs_req and data_req rise together -> handshake served first, data_grant on the IDLE cycle after.
REQ-037 SHALL cover: rx_nak four times with MAX_RETRY=3 -> three fifo_rewind pulses, then data_fail, then IDLE.
REQ-038 SHALL cover: no response with TIMEOUT_CYCLES=10 -> retry 10 cycles after D_TXWAIT; rx_ack coincident with expiry -> data_done.
REQ-039 SHALL cover: n_rst asserted in D_PAYLOAD -> outputs 0 asynchronously; a fresh request completes normally.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// ---------------------------------------------------------------------------
// usb_tx_pkg
//   Shared definitions for the USB transmit scheduler:
//     - encoder instruction codes driven on encode_instruction
//     - encoder status code that signals "packet complete"
//     - scheduler state enumeration
// ---------------------------------------------------------------------------
package usb_tx_pkg;

    // Encoder instruction codes
    localparam logic [3:0] INSTR_IDLE    = 4'b0000;
    localparam logic [3:0] INSTR_ACK     = 4'b0110;
    localparam logic [3:0] INSTR_NAK     = 4'b0011;
    localparam logic [3:0] INSTR_SYNC    = 4'b0100; // SYNC + DATA1 PID
    localparam logic [3:0] INSTR_PAYLOAD = 4'b0101;
    localparam logic [3:0] INSTR_CRC     = 4'b0111; // CRC + end of packet

    // Encoder status meaning "packet complete"
    localparam logic [2:0] STATUS_DONE = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HS_ISSUE,
        ST_HS_WAIT,
        ST_D_SYNC,
        ST_D_PAYLOAD,
        ST_D_CRC,
        ST_D_TXWAIT,
        ST_D_RSPWAIT
    } tx_state_e;

endpackage

// File: rtl/usb_timeout_cnt.sv
// ---------------------------------------------------------------------------
// usb_timeout_cnt
//   Down-counter used to bound the wait for a receiver handshake.
//   Ports:
//     clk, n_rst : clock, asynchronous active-low reset
//     load       : load LOAD_VALUE (takes priority over enable)
//     enable     : count down by one per cycle while non-zero
//     expire     : high while enabled and the count has reached zero
// ---------------------------------------------------------------------------
module usb_timeout_cnt #(
    parameter logic [15:0] LOAD_VALUE = 16'd1199
) (
    input  logic clk,
    input  logic n_rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    logic [15:0] count;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (enable && (count != '0)) begin
            count <= count - 16'd1;
        end
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/usb_tx_sched.sv
// ---------------------------------------------------------------------------
// usb_tx_sched
//   Schedules handshake (ACK/NAK) and DATA1 packets onto the USB encoder and
//   runs the DATA response wait with timeout and bounded retransmission.
//   Ports:
//     clk, n_rst           : clock, asynchronous active-low reset
//     hs_req, hs_nak       : handshake request (level) and type (0=ACK, 1=NAK)
//     data_req, data_len   : DATA1 request (level) and payload length 1..64
//     fifo_rd              : encoder FIFO read strobe, one pulse per byte
//     encode_status        : encoder status, STATUS_DONE = packet complete
//     rx_ack, rx_nak       : receiver handshake pulses
//     encode_instruction   : registered encoder command
//     hs_grant, data_grant : request acceptance pulses (cycle leaving IDLE)
//     fifo_rewind          : restore TX FIFO read pointer before a retry
//     data_done, data_fail : DATA transaction outcome pulses
//     busy                 : high whenever not in IDLE
// ---------------------------------------------------------------------------
module usb_tx_sched
    import usb_tx_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1200,
    parameter logic [1:0]  MAX_RETRY      = 2'd3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       hs_req,
    input  logic       hs_nak,
    input  logic       data_req,
    input  logic [6:0] data_len,
    input  logic       fifo_rd,
    input  logic [2:0] encode_status,
    input  logic       rx_ack,
    input  logic       rx_nak,
    output logic [3:0] encode_instruction,
    output logic       hs_grant,
    output logic       data_grant,
    output logic       fifo_rewind,
    output logic       data_done,
    output logic       data_fail,
    output logic       busy
);

    tx_state_e  state, state_nxt;
    logic [3:0] instr_nxt;
    logic [6:0] len_q;
    logic [6:0] byte_cnt;
    logic [1:0] retry_cnt;
    logic       status_done;
    logic       done_q;
    logic       done_rise;
    logic       run_q;        // low during reset and until the first edge after it
    logic       timer_load;
    logic       timer_expire;

    assign status_done = (encode_status == STATUS_DONE);
    assign done_rise   = status_done && !done_q;  // a held status counts once
    assign busy        = (state != ST_IDLE);

    usb_timeout_cnt #(
        .LOAD_VALUE (TIMEOUT_CYCLES - 16'd1)  // expires in the last allowed cycle
    ) u_timeout (
        .clk    (clk),
        .n_rst  (n_rst),
        .load   (timer_load),
        .enable (state == ST_D_RSPWAIT),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= ST_IDLE;
            encode_instruction <= INSTR_IDLE;
            len_q              <= '0;
            byte_cnt           <= '0;
            retry_cnt          <= '0;
            done_q             <= 1'b0;
            run_q              <= 1'b0;
        end else begin
            state              <= state_nxt;
            encode_instruction <= instr_nxt;
            done_q             <= status_done;
            run_q              <= 1'b1;

            if (data_grant) begin
                len_q     <= data_len;
                retry_cnt <= '0;
            end else if (fifo_rewind) begin
                retry_cnt <= retry_cnt + 2'd1;
            end

            if (data_grant || fifo_rewind) begin
                byte_cnt <= '0;
            end else if ((state == ST_D_PAYLOAD) && fifo_rd) begin
                byte_cnt <= byte_cnt + 7'd1;
            end
        end
    end

    // Grants are Mealy outputs so they coincide with leaving IDLE; run_q keeps
    // them (and thus any departure from IDLE) off while reset is asserted.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        instr_nxt   = encode_instruction;
        hs_grant    = 1'b0;
        data_grant  = 1'b0;
        fifo_rewind = 1'b0;
        data_done   = 1'b0;
        data_fail   = 1'b0;
        timer_load  = 1'b0;

        case (state)
            ST_IDLE: begin
                instr_nxt = INSTR_IDLE;
                if (run_q && hs_req) begin
                    hs_grant  = 1'b1;
                    state_nxt = ST_HS_ISSUE;
                    instr_nxt = hs_nak ? INSTR_NAK : INSTR_ACK;
                end else if (run_q && data_req) begin
                    data_grant = 1'b1;
                    state_nxt  = ST_D_SYNC;
                    instr_nxt  = INSTR_SYNC;
                end
            end

            ST_HS_ISSUE: state_nxt = ST_HS_WAIT;

            ST_HS_WAIT: begin
                if (done_rise) begin
                    state_nxt = ST_IDLE;
                    instr_nxt = INSTR_IDLE;
                end
            end

            ST_D_SYNC: begin
                state_nxt = ST_D_PAYLOAD;
                instr_nxt = INSTR_PAYLOAD;
            end

            ST_D_PAYLOAD: begin
                if (byte_cnt == len_q) begin
                    state_nxt = ST_D_CRC;
                    instr_nxt = INSTR_CRC;
                end
            end

            ST_D_CRC: begin
                if (done_rise) begin
                    state_nxt = ST_D_TXWAIT;
                    instr_nxt = INSTR_IDLE;
                end
            end

            ST_D_TXWAIT: begin
                timer_load = 1'b1;
                state_nxt  = ST_D_RSPWAIT;
            end

            ST_D_RSPWAIT: begin
                // ACK wins over a coincident NAK or timeout
                if (rx_ack) begin
                    data_done = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (rx_nak || timer_expire) begin
                    if (retry_cnt < MAX_RETRY) begin
                        fifo_rewind = 1'b1;
                        state_nxt   = ST_D_SYNC;
                        instr_nxt   = INSTR_SYNC;
                    end else begin
                        data_fail = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                instr_nxt = INSTR_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_sched
//   Directed bench for usb_tx_sched (TIMEOUT_CYCLES=10, MAX_RETRY=3).
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_usb_tx_sched;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       hs_req, hs_nak, data_req, fifo_rd, rx_ack, rx_nak;
    logic [6:0] data_len;
    logic [2:0] encode_status;
    logic [3:0] encode_instruction;
    logic       hs_grant, data_grant, fifo_rewind, data_done, data_fail, busy;

    int checks = 0;
    int errors = 0;

    // Pulse tallies, sampled at the rising edge
    int n_rewind = 0;
    int n_fail   = 0;
    int n_done   = 0;

    usb_tx_sched #(
        .TIMEOUT_CYCLES (16'd10),
        .MAX_RETRY      (2'd3)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .hs_req             (hs_req),
        .hs_nak             (hs_nak),
        .data_req           (data_req),
        .data_len           (data_len),
        .fifo_rd            (fifo_rd),
        .encode_status      (encode_status),
        .rx_ack             (rx_ack),
        .rx_nak             (rx_nak),
        .encode_instruction (encode_instruction),
        .hs_grant           (hs_grant),
        .data_grant         (data_grant),
        .fifo_rewind        (fifo_rewind),
        .data_done          (data_done),
        .data_fail          (data_fail),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rewind) n_rewind++;
        if (data_fail)   n_fail++;
        if (data_done)   n_done++;
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    // Called in a D_PAYLOAD cycle; returns with n bytes counted.
    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_rd = 1'b1;
            cyc();
        end
        fifo_rd = 1'b0;
    endtask

    // Called after the last byte; returns in the first D_RSPWAIT cycle.
    task automatic finish_crc();
        cyc();                      // D_CRC
        encode_status = 3'b010;
        cyc();                      // D_TXWAIT
        encode_status = 3'b000;
        cyc();                      // D_RSPWAIT, first cycle
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0;
        hs_req = 1'b1; hs_nak = 1'b0; data_req = 1'b1; data_len = 7'd1;
        fifo_rd = 1'b0; encode_status = 3'b000; rx_ack = 1'b0; rx_nak = 1'b0;
        repeat (2) cyc();
        #1;
        checks++; if (encode_instruction !== 4'b0000) begin errors++; $display("FAIL reset_instr: got %b want 0000", encode_instruction); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (hs_grant !== 1'b0 || data_grant !== 1'b0) begin errors++; $display("FAIL reset_grants: got hs=%b data=%b want 0 0", hs_grant, data_grant); end
        cyc();
        hs_req = 1'b0; data_req = 1'b0;
        n_rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
        repeat (2) cyc();
    endtask

    task automatic test_handshake_ack();
        hs_req = 1'b1; hs_nak = 1'b0;
        #1;
        checks++; if (hs_grant !== 1'b1) begin errors++; $display("FAIL ack_grant: got %b want 1", hs_grant); end
        cyc();                      // HS_ISSUE
        hs_req = 1'b0;
        #1;
        checks++; if (hs_grant !== 1'b0) begin errors++; $display("FAIL ack_grant_width: got %b want 0", hs_grant); end
        checks++; if (encode_instruction !== 4'b0110) begin errors++; $display("FAIL ack_issue_code: got %b want 0110", encode_instruction); end
        repeat (2) cyc();           // HS_WAIT, waiting
        #1;
        checks++; if (encode_instruction !== 4'b0110 || busy !== 1'b1) begin errors++; $display("FAIL ack_wait_code: got %b busy %b want 0110 busy 1", encode_instruction, busy); end
        encode_status = 3'b010;
        cyc();                      // IDLE
        encode_status = 3'b000;
        #1;
        checks++; if (encode_instruction !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL ack_end: got %b busy %b want 0000 busy 0", encode_instruction, busy); end
        cyc();
    endtask

    // NAK handshake; a status already at 010 before the grant must not end it.
    task automatic test_handshake_nak_held_status();
        encode_status = 3'b010;
        cyc();
        hs_req = 1'b1; hs_nak = 1'b1;
        cyc();                      // HS_ISSUE
        hs_req = 1'b0; hs_nak = 1'b0;
        #1;
        checks++; if (encode_instruction !== 4'b0011) begin errors++; $display("FAIL nak_issue_code: got %b want 0011", encode_instruction); end
        repeat (2) cyc();           // HS_WAIT with held status
        #1;
        checks++; if (encode_instruction !== 4'b0011 || busy !== 1'b1) begin errors++; $display("FAIL nak_held_status: got %b busy %b want 0011 busy 1", encode_instruction, busy); end
        encode_status = 3'b000;
        cyc();
        encode_status = 3'b010;
        cyc();                      // rising edge seen -> IDLE
        encode_status = 3'b000;
        #1;
        checks++; if (encode_instruction !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL nak_end: got %b busy %b want 0000 busy 0", encode_instruction, busy); end
        cyc();
    endtask

    task automatic test_data_ack();
        int rw0 = n_rewind;
        data_req = 1'b1; data_len = 7'd3;
        #1;
        checks++; if (data_grant !== 1'b1) begin errors++; $display("FAIL data_grant: got %b want 1", data_grant); end
        cyc();                      // D_SYNC
        data_req = 1'b0;
        rx_ack = 1'b1;              // must be ignored outside D_RSPWAIT
        #1;
        checks++; if (encode_instruction !== 4'b0100) begin errors++; $display("FAIL data_sync_code: got %b want 0100", encode_instruction); end
        checks++; if (data_done !== 1'b0) begin errors++; $display("FAIL data_ack_ignored: got %b want 0", data_done); end
        cyc();                      // D_PAYLOAD
        rx_ack = 1'b0;
        #1;
        checks++; if (encode_instruction !== 4'b0101) begin errors++; $display("FAIL data_payload_code: got %b want 0101", encode_instruction); end
        send_bytes(3);
        cyc();
        #1;
        checks++; if (encode_instruction !== 4'b0111) begin errors++; $display("FAIL data_crc_code: got %b want 0111", encode_instruction); end
        encode_status = 3'b010;
        cyc();                      // D_TXWAIT
        encode_status = 3'b000;
        #1;
        checks++; if (encode_instruction !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL data_txwait: got %b busy %b want 0000 busy 1", encode_instruction, busy); end
        cyc();                      // D_RSPWAIT
        rx_ack = 1'b1;
        #1;
        checks++; if (data_done !== 1'b1 || data_fail !== 1'b0) begin errors++; $display("FAIL data_done: got done %b fail %b want 1 0", data_done, data_fail); end
        cyc();
        rx_ack = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || data_done !== 1'b0) begin errors++; $display("FAIL data_idle: got busy %b done %b want 0 0", busy, data_done); end
        checks++; if (n_rewind - rw0 !== 0) begin errors++; $display("FAIL data_no_rewind: got %0d want 0", n_rewind - rw0); end
        cyc();
    endtask

    task automatic test_priority();
        hs_req = 1'b1; hs_nak = 1'b0; data_req = 1'b1; data_len = 7'd1;
        #1;
        checks++; if (hs_grant !== 1'b1 || data_grant !== 1'b0) begin errors++; $display("FAIL prio_first: got hs %b data %b want 1 0", hs_grant, data_grant); end
        cyc();                      // HS_ISSUE
        hs_req = 1'b0;
        cyc();                      // HS_WAIT
        encode_status = 3'b010;
        cyc();                      // IDLE
        encode_status = 3'b000;
        #1;
        checks++; if (data_grant !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL prio_data_next: got grant %b busy %b want 1 0", data_grant, busy); end
        cyc();                      // D_SYNC
        data_req = 1'b0;
        hs_req = 1'b1;              // arrives during DATA, must wait
        #1;
        checks++; if (hs_grant !== 1'b0) begin errors++; $display("FAIL prio_no_preempt_sync: got %b want 0", hs_grant); end
        cyc();                      // D_PAYLOAD
        send_bytes(1);
        finish_crc();
        #1;
        checks++; if (hs_grant !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL prio_no_preempt_rsp: got grant %b busy %b want 0 1", hs_grant, busy); end
        rx_ack = 1'b1;
        cyc();                      // IDLE
        rx_ack = 1'b0;
        #1;
        checks++; if (hs_grant !== 1'b1) begin errors++; $display("FAIL prio_hs_after_data: got %b want 1", hs_grant); end
        cyc();                      // HS_ISSUE
        hs_req = 1'b0;
        cyc();
        encode_status = 3'b010;
        cyc();
        encode_status = 3'b000;
        cyc();
    endtask

    task automatic test_nak_retry();
        int rw0 = n_rewind;
        int fl0 = n_fail;
        data_req = 1'b1; data_len = 7'd2;
        cyc();                      // D_SYNC
        data_req = 1'b0;
        cyc();                      // D_PAYLOAD
        for (int a = 0; a < 4; a++) begin
            fifo_rd = 1'b1;
            cyc();
            #1;
            checks++; if (encode_instruction !== 4'b0101) begin errors++; $display("FAIL retry_payload_%0d: got %b want 0101", a, encode_instruction); end
            cyc();
            fifo_rd = 1'b0;
            finish_crc();
            rx_nak = 1'b1;
            #1;
            if (a < 3) begin
                checks++; if (fifo_rewind !== 1'b1 || data_fail !== 1'b0) begin errors++; $display("FAIL retry_rewind_%0d: got rewind %b fail %b want 1 0", a, fifo_rewind, data_fail); end
            end else begin
                checks++; if (fifo_rewind !== 1'b0 || data_fail !== 1'b1) begin errors++; $display("FAIL retry_final_fail: got rewind %b fail %b want 0 1", fifo_rewind, data_fail); end
            end
            cyc();
            rx_nak = 1'b0;
            #1;
            if (a < 3) begin
                checks++; if (encode_instruction !== 4'b0100) begin errors++; $display("FAIL retry_resync_%0d: got %b want 0100", a, encode_instruction); end
                cyc();              // D_PAYLOAD
            end else begin
                checks++; if (busy !== 1'b0 || encode_instruction !== 4'b0000) begin errors++; $display("FAIL retry_idle: got busy %b instr %b want 0 0000", busy, encode_instruction); end
            end
        end
        checks++; if (n_rewind - rw0 !== 3 || n_fail - fl0 !== 1) begin errors++; $display("FAIL retry_totals: got rewinds %0d fails %0d want 3 1", n_rewind - rw0, n_fail - fl0); end
        cyc();
    endtask

    task automatic test_timeout();
        int rw0 = n_rewind;
        data_req = 1'b1; data_len = 7'd1;
        cyc();
        data_req = 1'b0;
        cyc();
        send_bytes(1);
        finish_crc();               // cycle 1 after D_TXWAIT
        for (int i = 1; i <= 10; i++) begin
            #1;
            checks++; if (fifo_rewind !== (i == 10)) begin errors++; $display("FAIL timeout_cycle_%0d: got rewind %b want %b", i, fifo_rewind, (i == 10)); end
            if (i < 10) cyc();
        end
        cyc();
        #1;
        checks++; if (encode_instruction !== 4'b0100) begin errors++; $display("FAIL timeout_resync: got %b want 0100", encode_instruction); end
        cyc();
        send_bytes(1);
        finish_crc();
        repeat (9) cyc();           // cycle 10: expiry
        rx_ack = 1'b1;
        #1;
        checks++; if (data_done !== 1'b1 || fifo_rewind !== 1'b0) begin errors++; $display("FAIL timeout_ack_wins: got done %b rewind %b want 1 0", data_done, fifo_rewind); end
        cyc();
        rx_ack = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || n_rewind - rw0 !== 1) begin errors++; $display("FAIL timeout_end: got busy %b rewinds %0d want 0 1", busy, n_rewind - rw0); end
        cyc();
    endtask

    task automatic test_reset_mid_packet();
        int dn0;
        data_req = 1'b1; data_len = 7'd4;
        cyc();
        data_req = 1'b0;
        cyc();                      // D_PAYLOAD
        send_bytes(2);
        #2;
        n_rst = 1'b0;
        #1;
        checks++; if (encode_instruction !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL midreset_async: got %b busy %b want 0000 busy 0", encode_instruction, busy); end
        cyc();
        n_rst = 1'b1;
        repeat (2) cyc();
        dn0 = n_done;
        data_req = 1'b1; data_len = 7'd2;
        cyc();
        data_req = 1'b0;
        #1;
        checks++; if (encode_instruction !== 4'b0100) begin errors++; $display("FAIL midreset_fresh_sync: got %b want 0100", encode_instruction); end
        cyc();
        send_bytes(2);
        cyc();
        #1;
        checks++; if (encode_instruction !== 4'b0111) begin errors++; $display("FAIL midreset_fresh_crc: got %b want 0111", encode_instruction); end
        encode_status = 3'b010;
        cyc();
        encode_status = 3'b000;
        cyc();
        rx_ack = 1'b1;
        cyc();
        rx_ack = 1'b0;
        #1;
        checks++; if (n_done - dn0 !== 1 || busy !== 1'b0) begin errors++; $display("FAIL midreset_fresh_done: got dones %0d busy %b want 1 0", n_done - dn0, busy); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_handshake_ack();
        test_handshake_nak_held_status();
        test_data_ack();
        test_priority();
        test_nak_retry();
        test_timeout();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
